hamming_encoder: RTL and testbench

- Clocked Hamming(7,4) encoder stage; sits directly upstream of the single-error-correcting decode stage and produces the 7-bit codewords it consumes.
- Accepts 4-bit data nibbles over a valid/ready handshake and computes parity bits.
- Optionally flips one codeword bit for error-correction testing.
- Buffers codewords in a small output FIFO and counts delivered words.

---
 rtl/hamming_if.sv | 28 ++
 rtl/hamming_encoder.sv | 113 +++++++++++
 tb/tb_hamming_encoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_if.sv
// Handshake bundle between the Hamming(7,4) encoder and its neighbours:
// nibble input side, error-injection controls, codeword output side and counters.
interface hamming_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             inject_en;
    logic [2:0]       inject_pos;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_data;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] inj_cnt;

    // Traffic generator / downstream consumer side.
    modport master (
        output in_valid, in_data, inject_en, inject_pos, out_ready,
        input  in_ready, out_valid, out_data, word_cnt, inj_cnt
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_data, inject_en, inject_pos, out_ready,
        output in_ready, out_valid, out_data, word_cnt, inj_cnt
    );
endinterface

// File: rtl/hamming_encoder.sv
// Clocked Hamming(7,4) encoder with optional single-bit error injection,
// a small circular output FIFO with registered head, and delivery counters.
module hamming_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    hamming_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [6:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic [6:0]       cw_clean;
    logic [6:0]       flip_mask;
    logic [6:0]       cw_push;
    logic [6:0]       head_nxt;
    logic [6:0]       out_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             do_inject;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] inj_cnt_q;

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = out_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.inj_cnt   = inj_cnt_q;

    // Encode the offered nibble and apply the optional single-bit flip.
    always_comb begin
        cw_clean    = '0;
        cw_clean[2] = bus.in_data[0];
        cw_clean[4] = bus.in_data[1];
        cw_clean[5] = bus.in_data[2];
        cw_clean[6] = bus.in_data[3];
        cw_clean[0] = bus.in_data[0] ^ bus.in_data[1] ^ bus.in_data[3];
        cw_clean[1] = bus.in_data[0] ^ bus.in_data[2] ^ bus.in_data[3];
        cw_clean[3] = bus.in_data[1] ^ bus.in_data[2] ^ bus.in_data[3];
        flip_mask   = '0;
        do_inject   = 1'b0;
        if (bus.inject_en && (bus.inject_pos != 3'd0)) begin
            flip_mask = 7'd1 << (bus.inject_pos - 3'd1);
            do_inject = push;
        end
        cw_push = cw_clean ^ flip_mask;
    end

    // Next occupancy, next read pointer and the word that will sit at the head.
    // When the next head slot is the one being written this cycle, bypass the array.
    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + OCC_W'(1);
            2'b01:   occ_nxt = occ - OCC_W'(1);
            default: occ_nxt = occ;
        endcase
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        if (push && (occ_nxt == OCC_W'(1))) begin
            head_nxt = cw_push;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Codeword storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cw_push;
        end
    end

    // Pointers, occupancy, registered head and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            out_q      <= '0;
            word_cnt_q <= '0;
            inj_cnt_q  <= '0;
        end else begin
            occ    <= occ_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (occ_nxt != '0) begin
                out_q <= head_nxt;
            end
            if (pop) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
            if (do_inject) begin
                inj_cnt_q <= inj_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hamming_encoder.sv
// Bench for hamming_encoder: table vectors, corner sequences and random traffic
// checked against a position-based Hamming model and a queue-based FIFO model.
module tb_hamming_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    hamming_if #(.CNT_W(CNT_W)) bus ();

    hamming_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: data fills non-power-of-two positions in order; parity
    // position p covers every other position whose index has bit p set.
    function automatic logic [6:0] enc_model(input logic [3:0] d);
        logic [6:0] cw;
        int k;
        logic par;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 7; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int j = 1; j <= 7; j++) begin
                if (j != p && (j & p) != 0) par ^= cw[j-1];
            end
            cw[p-1] = par;
        end
        return cw;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        logic [2:0] s;
        s = '0;
        for (int p = 1; p <= 7; p++) begin
            if (cw[p-1]) s ^= 3'(p);
        end
        return s;
    endfunction

    function automatic logic [6:0] correct(input logic [6:0] cw);
        logic [6:0] c;
        logic [2:0] s;
        c = cw;
        s = syndrome(cw);
        if (s != 3'd0) c[s-1] = ~c[s-1];
        return c;
    endfunction

    function automatic logic [3:0] nib_of(input logic [6:0] cw);
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

    // Cycle-level model of the FIFO and counters, evaluated on the falling edge.
    typedef struct {
        logic [6:0] cw;
        logic [3:0] nib;
    } item_t;

    item_t            q[$];
    logic [CNT_W-1:0] mdl_words = '0;
    logic [CNT_W-1:0] mdl_inj = '0;

    always @(negedge clk) begin
        item_t it;
        logic  in_fire;
        logic  out_fire;
        if (!rst_n) begin
            q.delete();
            mdl_words = '0;
            mdl_inj   = '0;
        end else begin
            check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
            check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            check("word_cnt", 32'(bus.word_cnt), 32'(mdl_words));
            check("inj_cnt", 32'(bus.inj_cnt), 32'(mdl_inj));
            if (q.size() > 0) check("out_data", 32'(bus.out_data), 32'(q[0].cw));
            in_fire  = bus.in_valid && (q.size() < DEPTH);
            out_fire = (q.size() > 0) && bus.out_ready;
            if (out_fire) begin
                check("decode_nib", 32'(nib_of(correct(bus.out_data))), 32'(q[0].nib));
                void'(q.pop_front());
                mdl_words = mdl_words + 1'b1;
            end
            if (in_fire) begin
                it.nib = bus.in_data;
                it.cw  = enc_model(bus.in_data);
                if (bus.inject_en && bus.inject_pos != 3'd0) begin
                    it.cw[bus.inject_pos-1] = ~it.cw[bus.inject_pos-1];
                    mdl_inj = mdl_inj + 1'b1;
                end
                q.push_back(it);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] nib;
        logic       en;
        logic [2:0] pos;
        logic [6:0] exp_cw;
        logic [6:0] clean;
        logic       inc;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [CNT_W-1:0] base_w;
        logic [CNT_W-1:0] base_i;
        logic [6:0]       held;

        vt[0]  = '{4'h0, 1'b0, 3'd0, 7'h00, 7'h00, 1'b0};
        vt[1]  = '{4'h1, 1'b0, 3'd0, 7'h07, 7'h07, 1'b0};
        vt[2]  = '{4'h2, 1'b0, 3'd0, 7'h19, 7'h19, 1'b0};
        vt[3]  = '{4'h4, 1'b0, 3'd0, 7'h2A, 7'h2A, 1'b0};
        vt[4]  = '{4'h8, 1'b0, 3'd0, 7'h4B, 7'h4B, 1'b0};
        vt[5]  = '{4'hF, 1'b0, 3'd0, 7'h7F, 7'h7F, 1'b0};
        vt[6]  = '{4'hB, 1'b0, 3'd0, 7'h55, 7'h55, 1'b0};
        vt[7]  = '{4'hB, 1'b1, 3'd3, 7'h51, 7'h55, 1'b1};
        vt[8]  = '{4'hB, 1'b1, 3'd0, 7'h55, 7'h55, 1'b0};
        vt[9]  = '{4'hB, 1'b1, 3'd7, 7'h15, 7'h55, 1'b1};
        vt[10] = '{4'h0, 1'b1, 3'd1, 7'h01, 7'h00, 1'b1};
        vt[11] = '{4'h6, 1'b0, 3'd0, 7'h33, 7'h33, 1'b0};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.inject_en  = 1'b0;
        bus.inject_pos = '0;
        bus.out_ready  = 1'b0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("rst_inj_cnt", 32'(bus.inj_cnt), 32'd0);

        // Table vectors: single word through an empty FIFO.
        for (int i = 0; i < 12; i++) begin
            base_w = mdl_words;
            base_i = mdl_inj;
            bus.in_valid   = 1'b1;
            bus.in_data    = vt[i].nib;
            bus.inject_en  = vt[i].en;
            bus.inject_pos = vt[i].pos;
            bus.out_ready  = 1'b1;
            step();
            bus.in_valid  = 1'b0;
            bus.inject_en = 1'b0;
            check("tbl_out_valid", 32'(bus.out_valid), 32'd1);
            check("tbl_out_data", 32'(bus.out_data), 32'(vt[i].exp_cw));
            check("tbl_corrected", 32'(correct(bus.out_data)), 32'(vt[i].clean));
            step();
            check("tbl_word_cnt", 32'(bus.word_cnt), 32'(base_w + CNT_W'(1)));
            check("tbl_inj_cnt", 32'(bus.inj_cnt), 32'(base_i + CNT_W'(vt[i].inc)));
        end

        // Sweep all nibbles: syndrome zero and data recovered.
        for (int n = 0; n < 16; n++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(n);
            step();
            bus.in_valid = 1'b0;
            check("sweep_cw", 32'(bus.out_data), 32'(enc_model(4'(n))));
            check("sweep_syn", 32'(syndrome(bus.out_data)), 32'd0);
            check("sweep_nib", 32'(nib_of(bus.out_data)), 32'(n));
            step();
        end

        // Fill with out_ready low: in_ready drops after DEPTH accepts, head holds.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        held = enc_model(4'h3);
        for (int i = 0; i < DEPTH + 3; i++) begin
            bus.in_data = 4'(3 + i);
            step();
            check("fill_in_ready", 32'(bus.in_ready), 32'(i + 1 < DEPTH));
            check("stall_hold", 32'(bus.out_data), 32'(held));
            check("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        // Release and stream 3*DEPTH+ words across pointer wraps.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 4; i++) begin
            bus.in_data = 4'(i * 5);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (DEPTH + 2) step();

        // Steady state: push and pop every cycle, one word per cycle.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            bus.in_data = 4'($urandom_range(0, 15));
            step();
        end
        base_w = mdl_words;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 4'($urandom_range(0, 15));
            step();
            check("steady_valid", 32'(bus.out_valid), 32'd1);
            check("steady_ready", 32'(bus.in_ready), 32'd1);
        end
        check("steady_rate", 32'(bus.word_cnt), 32'(base_w + CNT_W'(10)));
        bus.in_valid = 1'b0;
        repeat (DEPTH + 2) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_data    = 4'($urandom_range(0, 15));
            bus.inject_en  = 1'($urandom_range(0, 1));
            bus.inject_pos = 3'($urandom_range(0, 7));
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.inject_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) step();

        // Asynchronous reset with two words buffered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'h9;
        step();
        bus.in_data = 4'hA;
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_full", 32'(bus.in_ready), 32'(DEPTH > 2));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("arst_inj_cnt", 32'(bus.inj_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_idle", 32'(bus.out_valid), 32'd0);
            check("post_rst_cnt", 32'(bus.word_cnt), 32'd0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hB;
        step();
        bus.in_valid = 1'b0;
        check("post_rst_word", 32'(bus.out_data), 32'h55);
        step();
        check("post_rst_count", 32'(bus.word_cnt), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
